// File: rtl/serial_io_bridge.sv
// serial_io_bridge: byte-wide processor port to 8N1 UART, with a TX FIFO feeding
// the transmit engine and an RX FIFO buffering bytes from the receive engine.
module serial_io_bridge #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] proc_wr_data,
  input  logic       proc_wren,
  output logic       proc_wr_ready,
  input  logic       proc_rden,
  output logic [7:0] proc_rd_data,
  output logic       proc_rd_valid,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       rx_overrun
);

  // state | meaning
  // IDLE  | line idle high, waiting for work / a falling edge
  // START | start bit (TX drives 0, RX waits to the bit centre)
  // DATA  | 8 data bits, LSB first
  // STOP  | stop bit (TX drives 1, RX samples at its centre)
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [ADDR_W:0]  FIFO_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // ---------------- TX FIFO ----------------
  logic [7:0]        tx_mem_q [DEPTH];
  logic [ADDR_W-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [ADDR_W:0]   tx_count_q;
  logic              tx_push, tx_pop;

  assign proc_wr_ready = (tx_count_q != FIFO_FULL);
  assign tx_push       = proc_wren && proc_wr_ready;

  // TX FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= proc_wr_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + ADDR_W'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + ADDR_W'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count_q <= tx_count_q + (ADDR_W + 1)'(1);
        2'b01:   tx_count_q <= tx_count_q - (ADDR_W + 1)'(1);
        default: tx_count_q <= tx_count_q;
      endcase
    end
  end

  // ---------------- TX engine ----------------
  uart_state_t      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;

  // TX engine state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // TX next state: each state holds for one bit time, timed by a down-counter
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (tx_count_q != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rd_ptr_q];
          tx_cnt_d   = BIT_LAST;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_LAST;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == '0) tx_state_d = ST_IDLE;
        else                tx_cnt_d   = tx_cnt_q - CNT_W'(1);
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // Line level decoded from state so an async reset releases the line at once
  assign uart_tx = (tx_state_q == ST_START) ? 1'b0 :
                   (tx_state_q == ST_DATA)  ? tx_shift_q[0] : 1'b1;
  assign tx_busy = (tx_state_q != ST_IDLE);

  // ---------------- RX engine ----------------
  logic             rx_meta_q, rx_sync_q;
  uart_state_t      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_push_req;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX engine state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: half-bit wait after the falling edge, then sample at bit centres
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push_req = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_sync_q) begin
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = '0;
            rx_state_d = ST_DATA;
          end else begin
            rx_state_d = ST_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_LAST;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_push_req = rx_sync_q;
          rx_state_d  = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]        rx_mem_q [DEPTH];
  logic [ADDR_W-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [ADDR_W:0]   rx_count_q;
  logic              rx_full, rx_push, rx_pop, rx_overrun_q;

  assign rx_full       = (rx_count_q == FIFO_FULL);
  assign proc_rd_valid = (rx_count_q != '0);
  assign rx_pop        = proc_rden && proc_rd_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte
  assign rx_push       = rx_push_req && (!rx_full || rx_pop);
  assign proc_rd_data  = proc_rd_valid ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
  assign rx_overrun    = rx_overrun_q;

  // RX FIFO storage
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_shift_q;
  end

  // RX FIFO pointers, occupancy and sticky overrun flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      rx_count_q   <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + ADDR_W'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + ADDR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count_q <= rx_count_q + (ADDR_W + 1)'(1);
        2'b01:   rx_count_q <= rx_count_q - (ADDR_W + 1)'(1);
        default: rx_count_q <= rx_count_q;
      endcase
      if (rx_push_req && !rx_push) rx_overrun_q <= 1'b1;
    end
  end

endmodule
